// File: rtl/rs_rx_ctrl.sv
// 8N1 UART receiver with 16x oversampling, 7/8/9 majority vote and a one-byte
// holding register drained by a fetch pulse; sticky overrun and framing flags.
module rs_rx_ctrl #(
    parameter int unsigned CLK_HZ = 48_000_000
) (
    input  logic       rs_clk,
    input  logic       rs_reset,
    input  logic [3:0] rxBitRate,
    input  logic       xipRXD,
    input  logic       rxFetch,
    output logic [7:0] rxData,
    output logic       rxStatus,
    output logic       rxOverrun,
    output logic       rxFrameErr
);

    localparam int unsigned D0 = CLK_HZ / (16 * 1200);
    localparam int unsigned D1 = CLK_HZ / (16 * 2400);
    localparam int unsigned D2 = CLK_HZ / (16 * 4800);
    localparam int unsigned D3 = CLK_HZ / (16 * 9600);
    localparam int unsigned D4 = CLK_HZ / (16 * 19200);
    localparam int unsigned D5 = CLK_HZ / (16 * 38400);
    localparam int unsigned D6 = CLK_HZ / (16 * 57600);
    localparam int unsigned D7 = CLK_HZ / (16 * 115200);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_n;
    logic        rx_meta, rxs;
    logic [2:0]  rate_q;
    logic [23:0] div_cnt, div_lim;
    logic [3:0]  s_cnt, nx;
    logic        v7, v8, maj;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        armed;
    logic        done, stop_v;
    logic        tick, samp9;
    logic        start_det, shift_en, stop_evt;

    always_comb begin
        case (rate_q)
            3'd0:    div_lim = 24'(D0 - 1);
            3'd1:    div_lim = 24'(D1 - 1);
            3'd2:    div_lim = 24'(D2 - 1);
            3'd3:    div_lim = 24'(D3 - 1);
            3'd4:    div_lim = 24'(D4 - 1);
            3'd5:    div_lim = 24'(D5 - 1);
            3'd6:    div_lim = 24'(D6 - 1);
            default: div_lim = 24'(D7 - 1);
        endcase
    end

    // Sample n of a bit lands n ticks after the bit edge; 8 is mid-bit.
    assign tick  = (div_cnt == div_lim);
    assign nx    = s_cnt + 4'd1;
    assign samp9 = (state != IDLE) && tick && (nx == 4'd9);
    assign maj   = (v7 & v8) | (v7 & rxs) | (v8 & rxs);

    always_ff @(posedge rs_clk) begin
        if (rs_reset) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n   = state;
        start_det = 1'b0;
        shift_en  = 1'b0;
        stop_evt  = 1'b0;
        case (state)
            IDLE: begin
                if (armed && !rxs) begin
                    start_det = 1'b1;
                    state_n   = START;
                end
            end
            START: begin
                if (samp9) state_n = maj ? IDLE : DATA;
            end
            DATA: begin
                if (samp9) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (samp9) begin
                    stop_evt = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge rs_clk) begin
        if (rs_reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rate_q  <= 3'd7;
            div_cnt <= '0;
            s_cnt   <= '0;
            v7      <= 1'b1;
            v8      <= 1'b1;
            bit_cnt <= '0;
            shreg   <= '0;
            armed   <= 1'b0;
            done    <= 1'b0;
            stop_v  <= 1'b1;
        end else begin
            rx_meta <= xipRXD;
            rxs     <= rx_meta;
            done    <= stop_evt;
            if (stop_evt) stop_v <= maj;
            if (state == IDLE) begin
                // Counters idle at zero so the first tick is aligned to the start edge.
                rate_q  <= rxBitRate[3] ? 3'd7 : rxBitRate[2:0];
                div_cnt <= '0;
                s_cnt   <= '0;
                bit_cnt <= '0;
                if (rxs)       armed <= 1'b1;
                if (start_det) armed <= 1'b0;
            end else if (tick) begin
                div_cnt <= '0;
                s_cnt   <= nx;
                if (nx == 4'd7) v7 <= rxs;
                if (nx == 4'd8) v8 <= rxs;
            end else begin
                div_cnt <= div_cnt + 24'd1;
            end
            if (shift_en) begin
                shreg   <= {maj, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // A fetch coinciding with completion hands over the new byte instead of overrunning.
    always_ff @(posedge rs_clk) begin
        if (rs_reset) begin
            rxData     <= '0;
            rxStatus   <= 1'b0;
            rxOverrun  <= 1'b0;
            rxFrameErr <= 1'b0;
        end else if (done) begin
            if (!rxStatus || rxFetch) begin
                rxData     <= shreg;
                rxStatus   <= 1'b1;
                rxFrameErr <= ~stop_v;
                rxOverrun  <= 1'b0;
            end else begin
                rxOverrun  <= 1'b1;
            end
        end else if (rxFetch && rxStatus) begin
            rxStatus   <= 1'b0;
            rxOverrun  <= 1'b0;
            rxFrameErr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rs_rx_ctrl.sv
// Scoreboard bench for rs_rx_ctrl: every expected output tuple
// {status, overrun, frame_err, data} is queued before the stimulus that causes it.
module tb_rs_rx_ctrl;

    localparam int BIT7 = 16 * 26;
    localparam int BIT3 = 16 * 312;

    logic       clk = 1'b0;
    logic       rs_reset;
    logic [3:0] rxBitRate;
    logic       xipRXD;
    logic       rxFetch;
    logic [7:0] rxData;
    logic       rxStatus, rxOverrun, rxFrameErr;

    logic [10:0] sb[$];
    logic [10:0] prev, cur, exp_t;
    logic        mon_en = 1'b0;
    int          tests = 0;
    int          fails = 0;

    rs_rx_ctrl #(.CLK_HZ(48_000_000)) dut (
        .rs_clk(clk), .rs_reset(rs_reset), .rxBitRate(rxBitRate), .xipRXD(xipRXD),
        .rxFetch(rxFetch), .rxData(rxData), .rxStatus(rxStatus),
        .rxOverrun(rxOverrun), .rxFrameErr(rxFrameErr)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] tup(input logic st, input logic ov, input logic fe,
                                        input logic [7:0] d);
        return {st, ov, fe, d};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got st/ov/fe/data=%b/%b/%b/%h expected %b/%b/%b/%h",
                     name, act[10], act[9], act[8], act[7:0], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    // Monitor: any change of the visible outputs must match the next queued tuple.
    always @(negedge clk) begin
        if (mon_en) begin
            cur = {rxStatus, rxOverrun, rxFrameErr, rxData};
            if (cur !== prev) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_change: got %h with nothing expected", cur);
                end else begin
                    exp_t = sb.pop_front();
                    check("monitor", cur, exp_t);
                end
                prev = cur;
            end
        end
    end

    task automatic hold(input logic v, input int cyc);
        @(posedge clk);
        #1 xipRXD = v;
        repeat (cyc - 1) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stopv, input int bitc);
        hold(1'b0, bitc);
        for (int i = 0; i < 8; i++) hold(d[i], bitc);
        hold(stopv, bitc);
    endtask

    task automatic fetch();
        @(posedge clk);
        #1 rxFetch = 1'b1;
        @(posedge clk);
        #1 rxFetch = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s: %0d expected updates never appeared, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rs_reset  = 1'b1;
        rxBitRate = 4'd7;
        xipRXD    = 1'b1;
        rxFetch   = 1'b0;
        repeat (4) @(posedge clk);
        #1 rs_reset = 1'b0;
        check("reset_state", {rxStatus, rxOverrun, rxFrameErr, rxData}, 11'h000);
        prev   = 11'h000;
        mon_en = 1'b1;
        repeat (10) @(posedge clk);

        // 1: clean byte, then fetch clears status on the following edge
        sb.push_back(tup(1, 0, 0, 8'hA5));
        send_frame(8'hA5, 1'b1, BIT7);
        drain("t1_rx");
        sb.push_back(tup(0, 0, 0, 8'hA5));
        fetch();
        check("t1_fetch_clear", {rxStatus, rxOverrun, rxFrameErr, rxData}, tup(0, 0, 0, 8'hA5));

        // 2: 3-tick low glitch is a false start
        hold(1'b0, 3 * 26);
        hold(1'b1, 2 * BIT7);
        drain("t2_glitch");

        // 3: bad stop bit followed by a break yields one frame only
        sb.push_back(tup(1, 0, 1, 8'h3C));
        send_frame(8'h3C, 1'b0, BIT7);
        hold(1'b0, 3 * BIT7);
        hold(1'b1, BIT7);
        drain("t3_break");
        sb.push_back(tup(0, 0, 0, 8'h3C));
        fetch();
        sb.push_back(tup(1, 0, 0, 8'h55));
        send_frame(8'h55, 1'b1, BIT7);
        drain("t3_resync");
        sb.push_back(tup(0, 0, 0, 8'h55));
        fetch();

        // 4: overrun keeps the first byte
        sb.push_back(tup(1, 0, 0, 8'h11));
        send_frame(8'h11, 1'b1, BIT7);
        sb.push_back(tup(1, 1, 0, 8'h11));
        send_frame(8'h22, 1'b1, BIT7);
        drain("t4_overrun");
        sb.push_back(tup(0, 0, 0, 8'h11));
        fetch();
        check("t4_fetch_clear", {rxStatus, rxOverrun, rxFrameErr, rxData}, tup(0, 0, 0, 8'h11));

        // 5: fetch exactly in the completion cycle of the second byte.
        // Completion edge = 3 clocks of sync/detect + 153 samples (9 bits + 9) * 26 + 1.
        sb.push_back(tup(1, 0, 0, 8'h11));
        send_frame(8'h11, 1'b1, BIT7);
        sb.push_back(tup(1, 0, 0, 8'h22));
        fork
            send_frame(8'h22, 1'b1, BIT7);
            begin
                @(posedge clk);
                repeat (3 + 153 * 26) @(posedge clk);
                #1 rxFetch = 1'b1;
                @(posedge clk);
                #1 rxFetch = 1'b0;
            end
        join
        drain("t5_fetch_at_completion");
        check("t5_final", {rxStatus, rxOverrun, rxFrameErr, rxData}, tup(1, 0, 0, 8'h22));

        // 6: reset mid-byte, then a byte at 9600 baud
        hold(1'b0, BIT7);
        hold(1'b1, BIT7);
        hold(1'b0, 200);
        sb.push_back(tup(0, 0, 0, 8'h00));
        @(posedge clk);
        #1 rs_reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 rs_reset = 1'b0;
        xipRXD = 1'b1;
        check("t6_reset_outputs", {rxStatus, rxOverrun, rxFrameErr, rxData}, 11'h000);
        rxBitRate = 4'd3;
        hold(1'b1, 200);
        sb.push_back(tup(1, 0, 0, 8'h81));
        send_frame(8'h81, 1'b1, BIT3);
        drain("t6_9600");
        check("t6_final", {rxStatus, rxOverrun, rxFrameErr, rxData}, tup(1, 0, 0, 8'h81));

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
